// File: rtl/n64_vmode_ctrl_pkg.sv
// ============================================================================
//  Module : n64_vmode_ctrl_pkg
//  Brief  : State encodings, vinfo bit indices and helpers for n64_vmode_ctrl.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package n64_vmode_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_LOCKED  = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_REQ     = 3'd3,
    ST_ACKWAIT = 3'd4
  } vmode_state_e;

  localparam int         VINFO_PAL     = 1;
  localparam int         VINFO_480I    = 0;
  localparam logic [1:0] VINFO_DEFAULT = 2'b01;

  function automatic logic [3:0] cnt_sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/n64_vmode_ctrl.sv
// ============================================================================
//  Module : n64_vmode_ctrl
//  Brief  : Debounces {palmode,n64_480i} per frame and hands accepted modes to
//           downstream stages via a 4-phase req/ack handshake with blanking.
//           Optional ack timeout: define N64_VMODE_ACK_TIMEOUT_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module n64_vmode_ctrl
  import n64_vmode_ctrl_pkg::*;
#(
  parameter int STABLE_FRAMES      = 3,
  parameter int ACK_TIMEOUT_FRAMES = 8
) (
  input  logic       VCLK,
  input  logic       nRST,
  input  logic       nVDSYNC,
  input  logic [3:0] Sync_pre,
  input  logic [3:0] Sync_cur,
  input  logic [1:0] vinfo_i,
  input  logic       cfg_ack,
  output logic [1:0] vinfo_o,
  output logic       vinfo_valid,
  output logic       cfg_req,
  output logic       mode_chg,
  output logic       blank_o,
  output logic       cfg_err
);

  localparam logic [3:0] c_stable_cnt = 4'(STABLE_FRAMES);

  vmode_state_e r_state, w_state_nxt;
  logic [3:0]   r_cnt, w_cnt_nxt;
  logic [1:0]   r_cand, w_cand_nxt;
  logic [1:0]   r_vinfo, w_vinfo_nxt;
  logic         r_mode_chg, w_mode_chg_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_err, w_err_nxt;
  logic [3:0]   r_tocnt, w_tocnt_nxt;
  logic         w_frame_tick;

  // Rising edge of nVSYNC inside a valid sync nibble marks one frame
  assign w_frame_tick = !nVDSYNC && !Sync_pre[3] && Sync_cur[3];

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cand_nxt     = r_cand;
    w_vinfo_nxt    = r_vinfo;
    w_mode_chg_nxt = 1'b0;
    w_valid_nxt    = r_valid;
    w_err_nxt      = r_err;
    w_tocnt_nxt    = r_tocnt;
    case (r_state)
      ST_INIT, ST_CONFIRM: begin
        if (w_frame_tick) begin
          if (r_state == ST_CONFIRM && vinfo_i == r_vinfo) begin
            w_state_nxt = ST_LOCKED;
            w_cnt_nxt   = 4'd0;
          end else begin
            if (vinfo_i != r_cand) begin
              w_cand_nxt = vinfo_i;
              w_cnt_nxt  = 4'd1;
            end else begin
              w_cnt_nxt = cnt_sat_inc(r_cnt);
            end
            if (w_cnt_nxt == c_stable_cnt) begin
              w_state_nxt    = ST_REQ;
              w_vinfo_nxt    = vinfo_i;
              w_mode_chg_nxt = 1'b1;
              w_tocnt_nxt    = 4'd0;
            end
          end
        end
      end
      ST_LOCKED: begin
        if (w_frame_tick && vinfo_i != r_vinfo) begin
          w_cand_nxt = vinfo_i;
          w_cnt_nxt  = 4'd1;
          if (w_cnt_nxt == c_stable_cnt) begin
            w_state_nxt    = ST_REQ;
            w_vinfo_nxt    = vinfo_i;
            w_mode_chg_nxt = 1'b1;
            w_tocnt_nxt    = 4'd0;
          end else begin
            w_state_nxt = ST_CONFIRM;
          end
        end
      end
      ST_REQ: begin
        // An ack in the same cycle as a frame tick takes precedence
        if (cfg_ack) begin
          w_state_nxt = ST_ACKWAIT;
        end
`ifdef N64_VMODE_ACK_TIMEOUT_EN
        else if (w_frame_tick) begin
          w_tocnt_nxt = cnt_sat_inc(r_tocnt);
          if (w_tocnt_nxt == 4'(ACK_TIMEOUT_FRAMES)) begin
            w_state_nxt = ST_LOCKED;
            w_err_nxt   = 1'b1;
            w_valid_nxt = 1'b1;
          end
        end
`endif
      end
      ST_ACKWAIT: begin
        if (!cfg_ack) begin
          w_state_nxt = ST_LOCKED;
          w_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= ST_INIT;
      r_cnt      <= 4'd0;
      r_cand     <= VINFO_DEFAULT;
      r_vinfo    <= VINFO_DEFAULT;
      r_mode_chg <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_tocnt    <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cand     <= w_cand_nxt;
      r_vinfo    <= w_vinfo_nxt;
      r_mode_chg <= w_mode_chg_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
      r_tocnt    <= w_tocnt_nxt;
    end
  end

  assign vinfo_o     = r_vinfo;
  assign vinfo_valid = r_valid;
  assign mode_chg    = r_mode_chg;
  assign cfg_req     = (r_state == ST_REQ);
  assign blank_o     = (r_state != ST_LOCKED);

`ifdef N64_VMODE_ACK_TIMEOUT_EN
  assign cfg_err = r_err;
`else
  logic unused_timeout;
  assign unused_timeout = (ACK_TIMEOUT_FRAMES == 0) ^ r_err ^ (^r_tocnt);
  assign cfg_err = 1'b0;
`endif

  logic unused_sync;
  assign unused_sync = ^{Sync_pre[2:0], Sync_cur[2:0]};

endmodule

`default_nettype wire
